aludec_md: RTL and testbench

Parametrised successor to the multi-cycle ALU decoder. It keeps the combinational `alucontrol` decode and adds the HI/LO multiply/divide path: it decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO, runs an iterative radix-2 multiply or restoring divide over `WIDTH` cycles, and holds the HI/LO registers. It sits beside the ALU in the multi-cycle datapath. The main controller starts it with `start` and waits on `busy`/`done`.

---
 rtl/aludec_md_pkg.sv | 44 ++++
 rtl/aludec_md_muldiv_core.sv | 163 ++++++++++++++++
 rtl/aludec_md.sv | 87 ++++++++
 tb/tb_aludec_md.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aludec_md_pkg.sv
// Shared declarations for the ALU decoder with HI/LO multiply/divide.
//   funct_t       : 6-bit instruction funct field
//   FUNCT_*       : funct encodings used by the decoder and the mul/div unit
//   alucontrol_t  : 3-bit ALU control encodings
//   md_state_t    : mul/div sequencer states
//   is_muldiv()   : true for funct codes that launch a mul/div operation
package mips_decls_p;

   typedef logic [5:0] funct_t;

   localparam funct_t FUNCT_ADD   = 6'h20;
   localparam funct_t FUNCT_SUB   = 6'h22;
   localparam funct_t FUNCT_AND   = 6'h24;
   localparam funct_t FUNCT_OR    = 6'h25;
   localparam funct_t FUNCT_SLT   = 6'h2A;
   localparam funct_t FUNCT_MULT  = 6'h18;
   localparam funct_t FUNCT_MULTU = 6'h19;
   localparam funct_t FUNCT_DIV   = 6'h1A;
   localparam funct_t FUNCT_DIVU  = 6'h1B;
   localparam funct_t FUNCT_MFHI  = 6'h10;
   localparam funct_t FUNCT_MFLO  = 6'h12;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alucontrol_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_t;

   // MULT, MULTU, DIV and DIVU share the 0x18..0x1B block; bit 1 selects
   // divide and bit 0 selects the unsigned flavour.
   function automatic logic is_muldiv(input funct_t f);
      return (f[5:2] == 4'b0110);
   endfunction

endpackage

// File: rtl/aludec_md_muldiv_core.sv
// Iterative multiply/divide engine with HI/LO result registers.
//   clk, reset     : clock and asynchronous active-high reset
//   launch         : qualified one-cycle start request
//   isdiv          : 1 = divide, 0 = multiply (sampled on launch)
//   issigned       : 1 = signed operation (sampled on launch)
//   srca, srcb     : operands (dividend/divisor or multiplicand pair)
//   hi, lo         : result registers
//   busy           : operation in progress (RUN or FIX)
//   done           : one-cycle pulse, hi/lo hold the new result
// WIDTH must be even and at least 4.
module muldiv_core
   import mips_decls_p::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             launch,
   input  logic             isdiv,
   input  logic             issigned,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   md_state_t state, nextstate;

   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   lowreg;
   logic [WIDTH-1:0]   opb;
   logic               opdiv;
   logic               negres;
   logic               negrem;
   logic               divzero;

   logic               accept;
   logic               nega;
   logic               negb;
   logic [WIDTH-1:0]   maga;
   logic [WIDTH-1:0]   magb;
   logic [WIDTH:0]     mulsum;
   logic [WIDTH:0]     shifted;
   logic               ge;
   logic [WIDTH-1:0]   subres;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prodfix;
   logic [WIDTH-1:0]   quotfix;
   logic [WIDTH-1:0]   remfix;

   // A new operation may only begin when nothing is in flight; DONE counts
   // as free so back-to-back operations lose no cycle.
   assign accept = launch && ((state == IDLE) || (state == DONE));

   // The engine works on magnitudes; signs are remembered and fixed up once
   // at the end.
   assign nega = issigned & srca[WIDTH-1];
   assign negb = issigned & srcb[WIDTH-1];
   assign maga = nega ? -srca : srca;
   assign magb = negb ? -srcb : srcb;

   // Multiply step: {acc, lowreg} is the running product with the
   // multiplier shifting out of the bottom of lowreg.
   assign mulsum = {1'b0, acc} + (lowreg[0] ? {1'b0, opb} : '0);

   // Restoring divide step: acc is the partial remainder, lowreg shifts the
   // dividend out of the top and the quotient bits in at the bottom. When
   // the shifted remainder reaches the divisor the true difference is below
   // 2^WIDTH, so a WIDTH-bit subtraction is exact.
   assign shifted = {acc, lowreg[WIDTH-1]};
   assign ge      = (shifted >= {1'b0, opb});
   assign subres  = shifted[WIDTH-1:0] - opb;

   // Sign fix-up. Division by zero leaves the remainder equal to the
   // dividend magnitude, which after the dividend-sign correction equals
   // srca for both flavours; only the quotient needs forcing to all ones.
   // MIN / -1 falls out naturally: the magnitude quotient 2^(WIDTH-1)
   // negates back to itself.
   assign prod    = {acc, lowreg};
   assign prodfix = negres ? -prod : prod;
   assign quotfix = divzero ? '1 : (negres ? -lowreg : lowreg);
   assign remfix  = negrem ? -acc : acc;

   assign busy = (state == RUN) || (state == FIX);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextstate;
      end
   end

   // Sequencer: RUN spends exactly WIDTH cycles, the last iteration
   // happening on the edge where count is 1, then one FIX cycle.
   always_comb begin
      nextstate = state;
      case (state)
         IDLE: if (accept) nextstate = RUN;
         RUN:  if (count == CW'(1)) nextstate = FIX;
         FIX:  nextstate = DONE;
         DONE: nextstate = accept ? RUN : IDLE;
         default: nextstate = IDLE;
      endcase
   end

   // Datapath: operand capture on launch, one iteration per RUN cycle and
   // the corrected result written to HI/LO on the FIX edge so it is
   // visible throughout DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         acc     <= '0;
         lowreg  <= '0;
         opb     <= '0;
         opdiv   <= 1'b0;
         negres  <= 1'b0;
         negrem  <= 1'b0;
         divzero <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else if (accept) begin
         count   <= CW'(WIDTH);
         acc     <= '0;
         lowreg  <= maga;
         opb     <= magb;
         opdiv   <= isdiv;
         negres  <= nega ^ negb;
         negrem  <= isdiv & nega;
         divzero <= isdiv && (srcb == '0);
      end else if (state == RUN) begin
         count <= count - CW'(1);
         if (opdiv) begin
            if (ge) begin
               acc    <= subres;
               lowreg <= {lowreg[WIDTH-2:0], 1'b1};
            end else begin
               acc    <= shifted[WIDTH-1:0];
               lowreg <= {lowreg[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc    <= mulsum[WIDTH:1];
            lowreg <= {mulsum[0], lowreg[WIDTH-1:1]};
         end
      end else if (state == FIX) begin
         if (opdiv) begin
            hi <= remfix;
            lo <= quotfix;
         end else begin
            hi <= prodfix[2*WIDTH-1:WIDTH];
            lo <= prodfix[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/aludec_md.sv
// ALU decoder with HI/LO multiply/divide unit for the multi-cycle datapath.
//   clk, reset  : clock and asynchronous active-high reset
//   funct       : instruction funct field
//   aluop       : ALU operation class from the main controller
//   start       : one-cycle request to launch the decoded mul/div
//   srca, srcb  : operands (rs, rt)
//   alucontrol  : combinational ALU control
//   busy        : mul/div in progress
//   done        : one-cycle pulse, HI/LO updated
//   hilo_rd     : HI for MFHI, otherwise LO
//   stall       : HI/LO user instruction issued while the unit is busy
// WIDTH must be even and at least 4.
module aludec_md
   import mips_decls_p::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  funct_t           funct,
   input  logic [1:0]       aluop,
   input  logic             start,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [2:0]       alucontrol,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hilo_rd,
   output logic             stall
);

   alucontrol_t      aluctl;
   logic             rtype;
   logic             muldivop;
   logic             hiloop;
   logic             launch;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   assign rtype    = (aluop == 2'b10);
   assign muldivop = is_muldiv(funct);
   assign hiloop   = muldivop || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);

   // The core refuses launches while busy as well; gating here keeps a
   // stray start during an operation from ever reaching it.
   assign launch = start && rtype && muldivop && !busy;

   assign hilo_rd    = (funct == FUNCT_MFHI) ? hi : lo;
   assign stall      = busy && rtype && hiloop;
   assign alucontrol = aluctl;

   // ALU control decode: fixed operations for loads/stores, branches and
   // ori; R-type instructions decode funct, with add as the fallback.
   always_comb begin
      aluctl = ALU_ADD;
      case (aluop)
         2'b00: aluctl = ALU_ADD;
         2'b01: aluctl = ALU_SUB;
         2'b11: aluctl = ALU_OR;
         default: begin
            case (funct)
               FUNCT_ADD: aluctl = ALU_ADD;
               FUNCT_SUB: aluctl = ALU_SUB;
               FUNCT_AND: aluctl = ALU_AND;
               FUNCT_OR:  aluctl = ALU_OR;
               FUNCT_SLT: aluctl = ALU_SLT;
               default:   aluctl = ALU_ADD;
            endcase
         end
      endcase
   end

   muldiv_core #(.WIDTH(WIDTH)) core (
      .clk      (clk),
      .reset    (reset),
      .launch   (launch),
      .isdiv    (funct[1]),
      .issigned (!funct[0]),
      .srca     (srca),
      .srcb     (srcb),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done)
   );

endmodule

// File: tb/tb_aludec_md.sv
// Directed self-checking bench for aludec_md at WIDTH=32 and WIDTH=8.
module tb_aludec_md;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  funct;
   logic [1:0]  aluop;
   logic        start;
   logic [31:0] srca, srcb;
   logic [2:0]  alucontrol;
   logic        busy, done, stall;
   logic [31:0] hilo_rd;

   logic [5:0]  funct8;
   logic [1:0]  aluop8;
   logic        start8;
   logic [7:0]  srca8, srcb8;
   logic [2:0]  alucontrol8;
   logic        busy8, done8, stall8;
   logic [7:0]  hilo_rd8;

   int errors = 0;
   int checks = 0;

   // {aluop, funct, expected alucontrol}
   localparam logic [10:0] DECODE_VEC [10] = '{
      {2'b00, 6'h00, 3'b010}, {2'b01, 6'h00, 3'b110}, {2'b11, 6'h00, 3'b001},
      {2'b00, 6'h22, 3'b010}, {2'b10, 6'h20, 3'b010}, {2'b10, 6'h22, 3'b110},
      {2'b10, 6'h24, 3'b000}, {2'b10, 6'h25, 3'b001}, {2'b10, 6'h2A, 3'b111},
      {2'b10, 6'h3F, 3'b010}
   };

   always #5 clk = ~clk;

   aludec_md #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .funct      (funct),
      .aluop      (aluop),
      .start      (start),
      .srca       (srca),
      .srcb       (srcb),
      .alucontrol (alucontrol),
      .busy       (busy),
      .done       (done),
      .hilo_rd    (hilo_rd),
      .stall      (stall)
   );

   aludec_md #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .funct      (funct8),
      .aluop      (aluop8),
      .start      (start8),
      .srca       (srca8),
      .srcb       (srcb8),
      .alucontrol (alucontrol8),
      .busy       (busy8),
      .done       (done8),
      .hilo_rd    (hilo_rd8),
      .stall      (stall8)
   );

   // Drive a launch for exactly one rising edge; returns at the following
   // falling edge with start low.
   task automatic launchOnly(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      aluop = 2'b10;
      funct = f;
      srca  = a;
      srcb  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; edges counts rising edges since and including
   // the launch edge.
   task automatic waitDone(input int startEdges, output int edges);
      edges = startEdges;
      while (done !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output int edges);
      launchOnly(f, a, b);
      waitDone(1, edges);
   endtask

   task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
      aluop = 2'b10;
      funct = 6'h10;
      #1 hi = hilo_rd;
      funct = 6'h12;
      #1 lo = hilo_rd;
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      reset = 1'b1; start = 1'b0; aluop = 2'b00; funct = 6'h00; srca = '0; srcb = '0;
      start8 = 1'b0; aluop8 = 2'b00; funct8 = 6'h00; srca8 = '0; srcb8 = '0;
      repeat (2) @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
      end
      checks++;
      readHiLo(hi, lo);
      if (hi !== 32'h0 || lo !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_hilo: hi=%h lo=%h expected 0 0", hi, lo);
      end
      checks++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_decode();
      for (int i = 0; i < 10; i++) begin
         logic [10:0] v;
         v = DECODE_VEC[i];
         aluop = v[10:9];
         funct = v[8:3];
         #1;
         if (alucontrol !== v[2:0]) begin
            errors++;
            $display("[TB] FAIL decode aluop=%b funct=%h: got %b expected %b", v[10:9], v[8:3], alucontrol, v[2:0]);
         end
         checks++;
      end
      @(negedge clk);
   endtask

   task automatic test_mult();
      int e;
      logic [31:0] hi, lo;
      applyStimulus(6'h18, 32'hFFFFFFFD, 32'd7, e);
      if (e !== 34) begin
         errors++; $display("[TB] FAIL mult_latency: got %0d edges expected 34", e);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("[TB] FAIL busy_in_done: got %b expected 0", busy);
      end
      checks++;
      readHiLo(hi, lo);
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
         errors++; $display("[TB] FAIL mult_neg: hi=%h lo=%h expected ffffffff ffffffeb", hi, lo);
      end
      checks++;
      @(negedge clk);
      if (done !== 1'b0) begin
         errors++; $display("[TB] FAIL done_pulse: got %b expected 0", done);
      end
      checks++;
      applyStimulus(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, e);
      readHiLo(hi, lo);
      if (e !== 34 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         errors++; $display("[TB] FAIL multu: edges=%0d hi=%h lo=%h expected 34 fffffffe 00000001", e, hi, lo);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_div();
      int e;
      logic [31:0] hi, lo;
      logic [5:0]  fv [4] = '{6'h1B, 6'h1A, 6'h1A, 6'h1A};
      logic [31:0] av [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5};
      logic [31:0] bv [4] = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
      logic [31:0] ql [4] = '{32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
      logic [31:0] rh [4] = '{32'd2, 32'hFFFFFFFF, 32'h0, 32'd5};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(fv[i], av[i], bv[i], e);
         readHiLo(hi, lo);
         if (e !== 34 || hi !== rh[i] || lo !== ql[i]) begin
            errors++;
            $display("[TB] FAIL div_case%0d: edges=%0d hi=%h lo=%h expected 34 %h %h", i, e, hi, lo, rh[i], ql[i]);
         end
         checks++;
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int e;
      logic [31:0] hi, lo;
      launchOnly(6'h18, 32'd6, 32'd7);
      e = 1;
      repeat (9) begin @(negedge clk); e++; end
      funct = 6'h1A; srca = 32'd100; srcb = 32'd7; start = 1'b1;
      @(negedge clk);
      e++;
      start = 1'b0; funct = 6'h18;
      if (busy !== 1'b1) begin
         errors++; $display("[TB] FAIL ignore_busy: got %b expected 1", busy);
      end
      checks++;
      waitDone(e, e);
      readHiLo(hi, lo);
      if (e !== 34 || hi !== 32'h0 || lo !== 32'd42) begin
         errors++; $display("[TB] FAIL ignore_start: edges=%0d hi=%h lo=%h expected 34 0 2a", e, hi, lo);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int e;
      logic [31:0] hi, lo;
      applyStimulus(6'h19, 32'd3, 32'd5, e);
      readHiLo(hi, lo);
      if (e !== 34 || lo !== 32'd15) begin
         errors++; $display("[TB] FAIL b2b_first: edges=%0d lo=%h expected 34 f", e, lo);
      end
      checks++;
      applyStimulus(6'h1B, 32'd100, 32'd7, e);
      readHiLo(hi, lo);
      if (e !== 34 || hi !== 32'd2 || lo !== 32'd14) begin
         errors++; $display("[TB] FAIL b2b_second: edges=%0d hi=%h lo=%h expected 34 2 e", e, hi, lo);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_stall();
      int e;
      launchOnly(6'h18, 32'd2, 32'd3);
      funct = 6'h10;
      #1;
      if (stall !== 1'b1) begin
         errors++; $display("[TB] FAIL stall_mfhi: got %b expected 1", stall);
      end
      checks++;
      funct = 6'h20;
      #1;
      if (stall !== 1'b0) begin
         errors++; $display("[TB] FAIL stall_add: got %b expected 0", stall);
      end
      checks++;
      aluop = 2'b00; funct = 6'h10;
      #1;
      if (stall !== 1'b0) begin
         errors++; $display("[TB] FAIL stall_aluop00: got %b expected 0", stall);
      end
      checks++;
      aluop = 2'b10;
      waitDone(1, e);
      funct = 6'h10;
      #1;
      if (e !== 34 || stall !== 1'b0) begin
         errors++; $display("[TB] FAIL stall_done: edges=%0d stall=%b expected 34 0", e, stall);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      int e;
      int seen;
      logic [31:0] hi, lo;
      launchOnly(6'h1A, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      if (busy !== 1'b0) begin
         errors++; $display("[TB] FAIL midop_busy: got %b expected 0", busy);
      end
      checks++;
      readHiLo(hi, lo);
      if (hi !== 32'h0 || lo !== 32'h0) begin
         errors++; $display("[TB] FAIL midop_hilo: hi=%h lo=%h expected 0 0", hi, lo);
      end
      checks++;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      if (seen !== 0) begin
         errors++; $display("[TB] FAIL midop_nodone: got %0d done pulses expected 0", seen);
      end
      checks++;
      applyStimulus(6'h18, 32'd6, 32'd7, e);
      readHiLo(hi, lo);
      if (e !== 34 || hi !== 32'h0 || lo !== 32'd42) begin
         errors++; $display("[TB] FAIL midop_after: edges=%0d hi=%h lo=%h expected 34 0 2a", e, hi, lo);
      end
      checks++;
      @(negedge clk);
   endtask

   task automatic test_width8();
      int e;
      logic [5:0] fv [2] = '{6'h18, 6'h1B};
      logic [7:0] av [2] = '{8'h80, 8'hC8};
      logic [7:0] bv [2] = '{8'h80, 8'h03};
      logic [7:0] eh [2] = '{8'h40, 8'h02};
      logic [7:0] el [2] = '{8'h00, 8'h42};
      logic [7:0] hi, lo;
      for (int i = 0; i < 2; i++) begin
         aluop8 = 2'b10; funct8 = fv[i]; srca8 = av[i]; srcb8 = bv[i]; start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         e = 1;
         while (done8 !== 1'b1 && e < 40) begin
            @(negedge clk);
            e++;
         end
         funct8 = 6'h10;
         #1 hi = hilo_rd8;
         funct8 = 6'h12;
         #1 lo = hilo_rd8;
         if (e !== 10 || hi !== eh[i] || lo !== el[i]) begin
            errors++;
            $display("[TB] FAIL width8_case%0d: edges=%0d hi=%h lo=%h expected 10 %h %h", i, e, hi, lo, eh[i], el[i]);
         end
         checks++;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mult();
      test_div();
      test_ignore_start();
      test_back_to_back();
      test_stall();
      test_reset_midop();
      test_width8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
